// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use and multi-cycle stalls, branch flush.
// Define HAZARD_CTRL_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int MD_LAT = 4,
  parameter int CW     = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [NRD*AW-1:0] id_src,
  input  logic [NRD-1:0]    id_src_use,
  input  logic              id_branch_taken,
  input  logic              id_md_start,
  input  logic [AW-1:0]     exe_rn,
  input  logic              exe_wreg,
  input  logic              exe_m2reg,
  input  logic [AW-1:0]     mem_rn,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              if_flush,
  output logic [NRD*2-1:0]  fwd,
  output logic              md_busy,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  localparam int MW = $clog2(MD_LAT);

  logic [MW-1:0] r_mdCnt;
  logic          w_loadUse;
  logic [AW-1:0] w_src;

  // An EXE load cannot be forwarded yet, so it falls through to the MEM check and raises load-use.
  always_comb begin
    w_loadUse = 1'b0;
    fwd       = '0;
    w_src     = '0;
    for (int k = 0; k < NRD; k++) begin
      w_src = id_src[k*AW +: AW];
      if (id_src_use[k] && (w_src != '0)) begin
        if (exe_wreg && exe_m2reg && (exe_rn == w_src)) begin
          w_loadUse = 1'b1;
        end
        if (exe_wreg && !exe_m2reg && (exe_rn == w_src)) begin
          fwd[2*k +: 2] = 2'b01;
        end else if (mem_wreg && (mem_rn == w_src)) begin
          fwd[2*k +: 2] = mem_m2reg ? 2'b11 : 2'b10;
        end
      end
    end
  end

  assign md_busy    = (r_mdCnt != '0);
  assign stall      = w_loadUse | md_busy;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign if_flush   = id_branch_taken & ~stall;

  // A start held off by a stall is re-presented by the frozen ID stage and taken once stall drops.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_mdCnt <= '0;
    end else if (id_md_start && !stall) begin
      r_mdCnt <= MW'(MD_LAT - 1);
    end else if (r_mdCnt != '0) begin
      r_mdCnt <= r_mdCnt - MW'(1);
    end
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [CW-1:0] r_stallCnt;
  logic [CW-1:0] r_flushCnt;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (stall && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CW'(1);
      end
      if (if_flush && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CW'(1);
      end
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle-count model.
module tb_hazard_ctrl;

  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int MD_LAT = 4;
  localparam int CW     = 16;
`ifdef HAZARD_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic [NRD*AW-1:0] id_src;
  logic [NRD-1:0]    id_src_use;
  logic              id_branch_taken;
  logic              id_md_start;
  logic [AW-1:0]     exe_rn;
  logic              exe_wreg;
  logic              exe_m2reg;
  logic [AW-1:0]     mem_rn;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic              stall;
  logic              pc_write;
  logic              ifid_write;
  logic              if_flush;
  logic [NRD*2-1:0]  fwd;
  logic              md_busy;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     flush_cnt;

  int passCount  = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  // Model state: busy while the cycle number is below mBusyEnd.
  int mCycle    = 0;
  int mBusyEnd  = 0;
  int mStallCnt = 0;
  int mFlushCnt = 0;

  hazard_ctrl #(.AW(AW), .NRD(NRD), .MD_LAT(MD_LAT), .CW(CW)) dut (
    .Clock(Clock), .Resetn(Resetn), .id_src(id_src), .id_src_use(id_src_use),
    .id_branch_taken(id_branch_taken), .id_md_start(id_md_start),
    .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .fwd(fwd), .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] modelFwd(input int k);
    logic [AW-1:0] s;
    s = id_src[k*AW +: AW];
    if (!id_src_use[k] || s == 0) return 2'd0;
    if (exe_wreg && !exe_m2reg && exe_rn == s) return 2'd1;
    if (mem_wreg && mem_rn == s) return mem_m2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit modelStall();
    bit lu;
    lu = 1'b0;
    for (int k = 0; k < NRD; k++)
      if (id_src_use[k] && id_src[k*AW +: AW] != 0 && id_src[k*AW +: AW] == exe_rn && exe_wreg && exe_m2reg)
        lu = 1'b1;
    return lu || (mCycle < mBusyEnd);
  endfunction

  always @(posedge Clock) begin
    if (!Resetn) begin
      mBusyEnd  <= 0;
      mStallCnt <= 0;
      mFlushCnt <= 0;
    end else begin
      if (id_md_start && !modelStall()) mBusyEnd <= mCycle + MD_LAT;
      if (modelStall() && mStallCnt < CNT_MAX) mStallCnt <= mStallCnt + 1;
      if (id_branch_taken && !modelStall() && mFlushCnt < CNT_MAX) mFlushCnt <= mFlushCnt + 1;
    end
    mCycle <= mCycle + 1;
  end

  always @(negedge Clock) begin
    if (checkEn) begin
      logic [NRD*2-1:0] ef;
      bit es;
      ef = '0;
      for (int k = 0; k < NRD; k++) ef[2*k +: 2] = modelFwd(k);
      es = modelStall();
      checkOutput("fwd", 32'(fwd), 32'(ef));
      checkOutput("stall", 32'(stall), 32'(es));
      checkOutput("pc_write", 32'(pc_write), 32'(!es));
      checkOutput("ifid_write", 32'(ifid_write), 32'(!es));
      checkOutput("if_flush", 32'(if_flush), 32'(id_branch_taken && !es));
      checkOutput("md_busy", 32'(md_busy), 32'(mCycle < mBusyEnd));
      checkOutput("stall_cnt", 32'(stall_cnt), PERF ? 32'(mStallCnt) : 32'd0);
      checkOutput("flush_cnt", 32'(flush_cnt), PERF ? 32'(mFlushCnt) : 32'd0);
    end
  end

  task automatic applyStimulus();
    @(posedge Clock);
    #1;
  endtask

  task automatic setIdle();
    Resetn = 1'b1; id_src = '0; id_src_use = '0; id_branch_taken = 1'b0; id_md_start = 1'b0;
    exe_rn = '0; exe_wreg = 1'b0; exe_m2reg = 1'b0; mem_rn = '0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
  endtask

  initial begin
    setIdle();
    Resetn = 1'b0;
    applyStimulus();
    applyStimulus();
    Resetn = 1'b1;
    checkEn = 1'b1;
    #3;
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkOutput("rst md_busy", 32'(md_busy), 32'd0);
    checkOutput("rst pc_write", 32'(pc_write), 32'd1);
    checkOutput("rst ifid_write", 32'(ifid_write), 32'd1);
    checkOutput("rst if_flush", 32'(if_flush), 32'd0);
    checkOutput("rst fwd", 32'(fwd), 32'd0);

    // EXE ALU forward, and EXE priority over a simultaneous MEM match.
    applyStimulus();
    exe_rn = 5'd3; exe_wreg = 1'b1; id_src = {5'd0, 5'd3}; id_src_use = 2'b01;
    #3;
    checkOutput("exe fwd", 32'(fwd[1:0]), 32'd1);
    checkOutput("exe fwd stall", 32'(stall), 32'd0);
    applyStimulus();
    mem_rn = 5'd3; mem_wreg = 1'b1;
    #3;
    checkOutput("exe over mem fwd", 32'(fwd[1:0]), 32'd1);

    // Load-use stall with a branch that must be ignored, then MEM load forward and the flush.
    applyStimulus();
    setIdle();
    exe_rn = 5'd5; exe_wreg = 1'b1; exe_m2reg = 1'b1; id_src = {5'd5, 5'd0}; id_src_use = 2'b10;
    id_branch_taken = 1'b1;
    #3;
    checkOutput("loaduse stall", 32'(stall), 32'd1);
    checkOutput("loaduse pc_write", 32'(pc_write), 32'd0);
    checkOutput("branch in stall", 32'(if_flush), 32'd0);
    applyStimulus();
    exe_wreg = 1'b0; exe_m2reg = 1'b0; mem_rn = 5'd5; mem_wreg = 1'b1; mem_m2reg = 1'b1;
    #3;
    checkOutput("mem load fwd", 32'(fwd[3:2]), 32'd3);
    checkOutput("post loaduse stall", 32'(stall), 32'd0);
    checkOutput("branch flush", 32'(if_flush), 32'd1);
    checkOutput("stall_cnt one", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    applyStimulus();
    setIdle();
    #3;
    checkOutput("flush_cnt one", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

    // Multi-cycle op busy for exactly MD_LAT-1 cycles after the start edge.
    id_md_start = 1'b1;
    applyStimulus();
    id_md_start = 1'b0;
    for (int i = 0; i < MD_LAT - 1; i++) begin
      #3;
      checkOutput("md busy", 32'(md_busy), 32'd1);
      checkOutput("md stall", 32'(stall), 32'd1);
      applyStimulus();
    end
    #3;
    checkOutput("md done busy", 32'(md_busy), 32'd0);
    checkOutput("md done stall", 32'(stall), 32'd0);

    // Reset aborts an in-flight op; register 0 never forwards.
    applyStimulus();
    id_md_start = 1'b1;
    applyStimulus();
    id_md_start = 1'b0;
    applyStimulus();
    Resetn = 1'b0; exe_rn = 5'd0; exe_wreg = 1'b1; id_src = '0; id_src_use = 2'b11;
    #3;
    checkOutput("mid op busy", 32'(md_busy), 32'd1);
    checkOutput("r0 fwd", 32'(fwd), 32'd0);
    applyStimulus();
    #3;
    checkOutput("abort busy", 32'(md_busy), 32'd0);
    checkOutput("abort stall", 32'(stall), 32'd0);
    checkOutput("abort stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("abort flush_cnt", 32'(flush_cnt), 32'd0);
    Resetn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      Resetn          = ($urandom_range(0, 99) != 0);
      id_src          = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      id_src_use      = NRD'($urandom);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_md_start     = ($urandom_range(0, 7) == 0);
      exe_rn          = AW'($urandom_range(0, 3));
      exe_wreg        = 1'($urandom);
      exe_m2reg       = 1'($urandom);
      mem_rn          = AW'($urandom_range(0, 3));
      mem_wreg        = 1'($urandom);
      mem_m2reg       = 1'($urandom);
    end
    applyStimulus();
    @(negedge Clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
